// File: rtl/alu_pipe_ctrl.sv
// Hazard controller for the ID -> EX -> MEM -> WB integer pipe: operand forwarding,
// load-use bubbles, taken-branch squash and memory-busy freeze.
module alu_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int RAW          = 5
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           id_valid_i,
    input  logic [RAW-1:0] id_rs1_i,
    input  logic [RAW-1:0] id_rs2_i,
    input  logic           id_use_rs1_i,
    input  logic           id_use_rs2_i,
    input  logic [RAW-1:0] id_rd_i,
    input  logic           id_wb_i,
    input  logic           id_load_i,
    input  logic           br_resolved_i,
    input  logic           br_taken_i,
    input  logic           mem_busy_i,
    output logic           stall_if_o,
    output logic           stall_id_o,
    output logic           bubble_ex_o,
    output logic           kill_ex_o,
    output logic           redirect_o,
    output logic [1:0]     fwd1_sel_o,
    output logic [1:0]     fwd2_sel_o,
    output logic [1:0]     state_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_MWAIT  = 2'd3;

    localparam logic [2:0]     FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [RAW-1:0] REG_X0     = '0;

    logic [1:0]     state;
    logic [1:0]     state_nx;
    logic [1:0]     saved_state;
    logic [1:0]     saved_nx;
    logic [1:0]     eff_state;
    logic [2:0]     flush_cnt;
    logic [2:0]     cnt_nx;

    logic [RAW-1:0] ex_rd;
    logic           ex_wb;
    logic           ex_load;
    logic [RAW-1:0] mem_rd;
    logic           mem_wb;

    logic           br_take;
    logic           lu_rs1;
    logic           lu_rs2;
    logic           load_use;

    function automatic logic [1:0] fwd_pick(
        input logic           use_rs,
        input logic [RAW-1:0] rs,
        input logic [RAW-1:0] e_rd,
        input logic           e_wb,
        input logic           e_ld,
        input logic [RAW-1:0] m_rd,
        input logic           m_wb
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_rs && rs != REG_X0) begin
            if (rs == e_rd && e_wb && !e_ld) begin
                sel = 2'd1;
            end else if (rs == m_rd && m_wb) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    // Leaving MWAIT, the cycle busy drops already behaves as the state that was interrupted,
    // so a pending kill is never lost to an idle resume cycle.
    always_comb begin
        eff_state = (state == ST_MWAIT && !mem_busy_i) ? saved_state : state;
        br_take   = br_resolved_i && br_taken_i &&
                    (eff_state == ST_RUN || eff_state == ST_LSTALL);
        lu_rs1    = id_use_rs1_i && (id_rs1_i != REG_X0) && (id_rs1_i == ex_rd) && ex_load && ex_wb;
        lu_rs2    = id_use_rs2_i && (id_rs2_i != REG_X0) && (id_rs2_i == ex_rd) && ex_load && ex_wb;
        load_use  = (eff_state == ST_RUN) && id_valid_i && (lu_rs1 || lu_rs2);
    end

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        kill_ex_o   = 1'b0;
        redirect_o  = 1'b0;
        fwd1_sel_o  = fwd_pick(id_use_rs1_i, id_rs1_i, ex_rd, ex_wb, ex_load, mem_rd, mem_wb);
        fwd2_sel_o  = fwd_pick(id_use_rs2_i, id_rs2_i, ex_rd, ex_wb, ex_load, mem_rd, mem_wb);
        state_o     = state;
        if (mem_busy_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
        end else if (eff_state == ST_FLUSH) begin
            kill_ex_o   = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (br_take) begin
            redirect_o  = 1'b1;
            kill_ex_o   = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        saved_nx = saved_state;
        cnt_nx   = flush_cnt;
        if (mem_busy_i) begin
            state_nx = ST_MWAIT;
            if (state != ST_MWAIT) begin
                saved_nx = state;
            end
        end else if (br_take) begin
            cnt_nx   = FLUSH_LOAD;
            state_nx = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (eff_state)
                ST_RUN:    state_nx = load_use ? ST_LSTALL : ST_RUN;
                ST_LSTALL: state_nx = ST_RUN;
                ST_FLUSH: begin
                    cnt_nx   = (flush_cnt != 3'd0) ? (flush_cnt - 3'd1) : 3'd0;
                    state_nx = (flush_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
                end
                default:   state_nx = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            flush_cnt   <= 3'd0;
        end else begin
            state       <= state_nx;
            saved_state <= saved_nx;
            flush_cnt   <= cnt_nx;
        end
    end

    // Shadow stage info freezes with the pipe; a bubble or kill turns the EX slot into a NOP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_rd   <= '0;
            ex_wb   <= 1'b0;
            ex_load <= 1'b0;
            mem_rd  <= '0;
            mem_wb  <= 1'b0;
        end else if (!mem_busy_i) begin
            mem_rd <= ex_rd;
            mem_wb <= ex_wb;
            if (bubble_ex_o || !id_valid_i) begin
                ex_rd   <= '0;
                ex_wb   <= 1'b0;
                ex_load <= 1'b0;
            end else begin
                ex_rd   <= id_rd_i;
                ex_wb   <= id_wb_i;
                ex_load <= id_load_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Directed self-checking bench for alu_pipe_ctrl; expected output vectors are hand-derived.
module tb_alu_pipe_ctrl;

    logic       CLK;
    logic       RST;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_use_rs1_i;
    logic       id_use_rs2_i;
    logic [4:0] id_rd_i;
    logic       id_wb_i;
    logic       id_load_i;
    logic       br_resolved_i;
    logic       br_taken_i;
    logic       mem_busy_i;
    logic       stall_if_o;
    logic       stall_id_o;
    logic       bubble_ex_o;
    logic       kill_ex_o;
    logic       redirect_o;
    logic [1:0] fwd1_sel_o;
    logic [1:0] fwd2_sel_o;
    logic [1:0] state_o;

    // {stall_if, stall_id, bubble_ex, kill_ex, redirect, fwd1, fwd2, state}
    logic [10:0] obs;
    logic [10:0] exp_v;
    int          n_cmp;
    int          n_fail;

    assign obs = {stall_if_o, stall_id_o, bubble_ex_o, kill_ex_o, redirect_o,
                  fwd1_sel_o, fwd2_sel_o, state_o};

    alu_pipe_ctrl #(.FLUSH_CYCLES(2), .RAW(5)) dut (
        .CLK(CLK), .RST(RST),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_wb_i(id_wb_i), .id_load_i(id_load_i),
        .br_resolved_i(br_resolved_i), .br_taken_i(br_taken_i), .mem_busy_i(mem_busy_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .bubble_ex_o(bubble_ex_o),
        .kill_ex_o(kill_ex_o), .redirect_o(redirect_o),
        .fwd1_sel_o(fwd1_sel_o), .fwd2_sel_o(fwd2_sel_o), .state_o(state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic wb, input logic ld);
        id_valid_i   = v;
        id_rs1_i     = rs1;
        id_use_rs1_i = u1;
        id_rs2_i     = rs2;
        id_use_rs2_i = u2;
        id_rd_i      = rd;
        id_wb_i      = wb;
        id_load_i    = ld;
    endtask

    task automatic clear_inputs();
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        br_resolved_i = 1'b0;
        br_taken_i    = 1'b0;
        mem_busy_i    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL reset_idle obs=%b exp=%b", obs, exp_v); end
        drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        do_reset();
        drive_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL reset_shadow obs=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL b2b_first obs=%b exp=%b", obs, exp_v); end
        tick();
        drive_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
        exp_v = {5'b00000, 2'd1, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL b2b_fwd_ex obs=%b exp=%b", obs, exp_v); end
        tick();
        drive_id(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        exp_v = {5'b00000, 2'd1, 2'd2, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL b2b_fwd_mem obs=%b exp=%b", obs, exp_v); end
        tick();
        drive_id(1'b1, 5'd6, 1'b1, 5'd6, 1'b0, 5'd9, 1'b0, 1'b0);
        exp_v = {5'b00000, 2'd1, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL b2b_ex_priority obs=%b exp=%b", obs, exp_v); end
        tick();
        drive_id(1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        exp_v = {5'b00000, 2'd0, 2'd2, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL b2b_no_wb obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        exp_v = {5'b11100, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL lu_stall obs=%b exp=%b", obs, exp_v); end
        tick();
        exp_v = {5'b00000, 2'd0, 2'd2, 2'd1};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL lu_lstall obs=%b exp=%b", obs, exp_v); end
        tick();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL lu_back_run obs=%b exp=%b", obs, exp_v); end
        tick();
        drive_id(1'b1, 5'd9, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL lu_unused_rs obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        br_resolved_i = 1'b1;
        br_taken_i    = 1'b1;
        exp_v = {5'b00111, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL br_resolve obs=%b exp=%b", obs, exp_v); end
        tick();
        exp_v = {5'b00110, 2'd0, 2'd0, 2'd2};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL br_flush_ignore obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL br_back_run obs=%b exp=%b", obs, exp_v); end
        br_resolved_i = 1'b1;
        br_taken_i    = 1'b0;
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL br_not_taken obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL br_not_taken_after obs=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        br_resolved_i = 1'b1;
        br_taken_i    = 1'b1;
        tick();
        clear_inputs();
        mem_busy_i = 1'b1;
        exp_v = {5'b11000, 2'd0, 2'd0, 2'd2};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_enter obs=%b exp=%b", obs, exp_v); end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = {5'b11000, 2'd0, 2'd0, 2'd3};
            #2; n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_hold%0d obs=%b exp=%b", i, obs, exp_v); end
        end
        tick();
        mem_busy_i = 1'b0;
        exp_v = {5'b00110, 2'd0, 2'd0, 2'd3};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_resume_kill obs=%b exp=%b", obs, exp_v); end
        tick();
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_back_run obs=%b exp=%b", obs, exp_v); end
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        mem_busy_i = 1'b1;
        exp_v = {5'b11000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_over_lu obs=%b exp=%b", obs, exp_v); end
        tick();
        mem_busy_i = 1'b0;
        exp_v = {5'b11100, 2'd0, 2'd0, 2'd3};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_lu_after obs=%b exp=%b", obs, exp_v); end
        tick();
        exp_v = {5'b00000, 2'd0, 2'd2, 2'd1};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL mw_lstall obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
    endtask

    task automatic test_x0_priority();
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL x0_load obs=%b exp=%b", obs, exp_v); end
        tick();
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL x0_fwd obs=%b exp=%b", obs, exp_v); end
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        br_resolved_i = 1'b1;
        br_taken_i    = 1'b1;
        exp_v = {5'b00111, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL prio_br_lu obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
        exp_v = {5'b00110, 2'd0, 2'd0, 2'd2};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL prio_flush obs=%b exp=%b", obs, exp_v); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        br_resolved_i = 1'b1;
        br_taken_i    = 1'b1;
        tick();
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL rst_in_flush obs=%b exp=%b", obs, exp_v); end
        tick();
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL rst_flush_after obs=%b exp=%b", obs, exp_v); end
        do_reset();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        clear_inputs();
        mem_busy_i = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        mem_busy_i = 1'b0;
        drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        exp_v = {5'b00000, 2'd0, 2'd0, 2'd0};
        #2; n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("[TB] FAIL rst_in_mwait obs=%b exp=%b", obs, exp_v); end
        tick();
        clear_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        RST    = 1'b1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_x0_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
